ex_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the EX stage of the pipelined core. It keeps a 4-deep shadow of destination-register information (EX, EX/LS, LS/WB, retired) and uses it to drive the EX operand-forwarding selects. It also detects load-use hazards, inserting one bubble each time, and sequences the multi-cycle divider with a start pulse and a stall until the divider reports done. Stall, bubble and flush outputs go to the IF/ID, ID/EX and EX/LS pipeline registers.

---
 rtl/ex_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
// Hazard and sequencing controller for the EX stage. A four-deep shadow of
// instruction register info (ex, ls, wb, rt) drives the EX operand-forwarding
// selects, detects load-use hazards (one bubble each) and sequences the
// multi-cycle divider (start pulse, then stall until done).
//
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   id_valid_i              ID holds a valid instruction
//   id_rs1_i, id_rs2_i      ID source register indices
//   id_rd_i                 ID destination register index
//   id_wen_i, id_lden_i     ID writes rd / ID is a load
//   id_div_i                ID uses the divider
//   is_jump_i               EX resolved a taken branch or jump
//   div_done_i              divider result valid this cycle
//   rs1_sel_o, rs2_sel_o    forwarding selects for EX (0 RF, 1 EX/LS, 2 LS/WB, 3 WB)
//   stall_if_o, stall_id_o  hold the PC and IF/ID
//   bubble_ex_o             load a NOP into ID/EX
//   flush_id_o              kill IF/ID
//   stall_ex_o              hold ID/EX, NOP into EX/LS
//   div_start_o             one-cycle divider start pulse
//
// Optional build macro EX_HAZ_PERF_EN adds perf_lu_cnt_o, perf_div_cnt_o and
// div_hang_o (divider busy longer than DIV_MAX_CYC cycles).
module ex_hazard_ctrl #(
  parameter int DIV_MAX_CYC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic [4:0] id_rd_i,
  input  logic       id_wen_i,
  input  logic       id_lden_i,
  input  logic       id_div_i,
  input  logic       is_jump_i,
  input  logic       div_done_i,
  output logic [1:0] rs1_sel_o,
  output logic [1:0] rs2_sel_o,
  output logic       stall_if_o,
  output logic       stall_id_o,
  output logic       bubble_ex_o,
  output logic       flush_id_o,
  output logic       stall_ex_o,
  output logic       div_start_o
`ifdef EX_HAZ_PERF_EN
  ,
  output logic [31:0] perf_lu_cnt_o,
  output logic [31:0] perf_div_cnt_o,
  output logic        div_hang_o
`endif
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wen;
    logic       lden;
    logic       div;
  } slot_t;

  typedef enum logic {IDLE, BUSY} div_state_t;

  slot_t      ex_slot, ls_slot, wb_slot, rt_slot;
  slot_t      id_slot;
  div_state_t state, state_next;
  logic       lu;
  logic       lu_kept;

  // A slot supplies a source operand when it really writes a non-zero rd
  function automatic logic produces(input slot_t s, input logic [4:0] src);
    return s.valid && s.wen && (s.rd != 5'd0) && (s.rd == src);
  endfunction

  // Youngest producer wins: ls before wb before rt
  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t ls,
                                         input slot_t wb, input slot_t rt,
                                         input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'd0;
    if (ex.valid) begin
      if (produces(ls, src))      sel = 2'd1;
      else if (produces(wb, src)) sel = 2'd2;
      else if (produces(rt, src)) sel = 2'd3;
    end
    return sel;
  endfunction

  assign id_slot = '{valid: 1'b1, rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i,
                     wen: id_wen_i, lden: id_lden_i, div: id_div_i};

  assign rs1_sel_o = fwd_sel(ex_slot, ls_slot, wb_slot, rt_slot, ex_slot.rs1);
  assign rs2_sel_o = fwd_sel(ex_slot, ls_slot, wb_slot, rt_slot, ex_slot.rs2);

  assign lu = id_valid_i && ex_slot.valid && ex_slot.lden && ex_slot.wen &&
              (ex_slot.rd != 5'd0) &&
              ((ex_slot.rd == id_rs1_i) || (ex_slot.rd == id_rs2_i));

  // A taken jump kills the ID consumer, so its load-use stall is dropped
  assign lu_kept = lu && !is_jump_i;

  // Divider sequencing: start pulse and stall on entry, stall until done
  always_comb begin
    state_next  = state;
    div_start_o = 1'b0;
    stall_ex_o  = 1'b0;
    case (state)
      IDLE: begin
        if (ex_slot.valid && ex_slot.div) begin
          div_start_o = 1'b1;
          stall_ex_o  = 1'b1;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        if (div_done_i) begin
          state_next = IDLE;
        end else begin
          stall_ex_o = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A divide stall masks jump flushes and load-use bubbles
  assign stall_if_o  = lu_kept || stall_ex_o;
  assign stall_id_o  = lu_kept || stall_ex_o;
  assign bubble_ex_o = !stall_ex_o && (lu || is_jump_i);
  assign flush_id_o  = !stall_ex_o && is_jump_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Shadow pipeline: ex holds during a divide, ls receives a NOP meanwhile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot <= '0;
      ls_slot <= '0;
      wb_slot <= '0;
      rt_slot <= '0;
    end else begin
      if (!stall_ex_o) begin
        if (bubble_ex_o || !id_valid_i) ex_slot <= '0;
        else                            ex_slot <= id_slot;
      end
      ls_slot <= stall_ex_o ? '0 : ex_slot;
      wb_slot <= ls_slot;
      rt_slot <= wb_slot;
    end
  end

  logic unused_rt;
  assign unused_rt = ^{rt_slot.rs1, rt_slot.rs2, rt_slot.lden, rt_slot.div};

`ifdef EX_HAZ_PERF_EN
  logic [31:0] busy_cnt;

  // Event counters wrap naturally; busy_cnt saturates so hang stays sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_cnt_o  <= '0;
      perf_div_cnt_o <= '0;
      busy_cnt       <= '0;
      div_hang_o     <= 1'b0;
    end else begin
      if (lu_kept)    perf_lu_cnt_o  <= perf_lu_cnt_o + 32'd1;
      if (stall_ex_o) perf_div_cnt_o <= perf_div_cnt_o + 32'd1;
      if (state == BUSY) begin
        if (busy_cnt != '1) busy_cnt <= busy_cnt + 32'd1;
        if (busy_cnt >= 32'(DIV_MAX_CYC)) div_hang_o <= 1'b1;
      end else begin
        busy_cnt   <= '0;
        div_hang_o <= 1'b0;
      end
    end
  end
`else
  logic [31:0] unused_div_max;
  assign unused_div_max = 32'(DIV_MAX_CYC);
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed self-checking bench for ex_hazard_ctrl: a cycle-by-cycle vector
// table for forwarding and load-use cases, then hand-written sequences for
// the divider, a mid-division reset and done-while-idle.
module tb_ex_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       id_valid_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic       id_wen_i, id_lden_i, id_div_i;
  logic       is_jump_i, div_done_i;
  logic [1:0] rs1_sel_o, rs2_sel_o;
  logic       stall_if_o, stall_id_o, bubble_ex_o, flush_id_o;
  logic       stall_ex_o, div_start_o;

  int checks = 0;
  int errors = 0;

  // One cycle of stimulus plus the outputs expected during that cycle.
  // flags = {stall_if/id, bubble_ex, flush_id, stall_ex, div_start}
  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       wen, lden, div, jmp, done;
    logic [1:0] e1, e2;
    logic [4:0] flags;
  } tv_t;

  tv_t tbl[$];

  ex_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rd_i(id_rd_i), .id_wen_i(id_wen_i), .id_lden_i(id_lden_i),
    .id_div_i(id_div_i), .is_jump_i(is_jump_i), .div_done_i(div_done_i),
    .rs1_sel_o(rs1_sel_o), .rs2_sel_o(rs2_sel_o),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
    .bubble_ex_o(bubble_ex_o), .flush_id_o(flush_id_o),
    .stall_ex_o(stall_ex_o), .div_start_o(div_start_o)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tv_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic wen, input logic lden,
                             input logic div, input logic jmp, input logic done,
                             input logic [1:0] e1, input logic [1:0] e2,
                             input logic [4:0] flags);
    tv_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.wen = wen; t.lden = lden;
    t.div = div; t.jmp = jmp; t.done = done; t.e1 = e1; t.e2 = e2; t.flags = flags;
    return t;
  endfunction

  function automatic tv_t idl();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000);
  endfunction

  // Three empty cycles drain every shadow slot between sequences
  task automatic drain();
    for (int i = 0; i < 3; i++) tbl.push_back(idl());
  endtask

  task automatic applyStimulus(input tv_t t);
    id_valid_i = t.v;
    id_rs1_i   = t.rs1;
    id_rs2_i   = t.rs2;
    id_rd_i    = t.rd;
    id_wen_i   = t.wen;
    id_lden_i  = t.lden;
    id_div_i   = t.div;
    is_jump_i  = t.jmp;
    div_done_i = t.done;
  endtask

  task automatic cmp(input string tag, input string what, input logic [1:0] got,
                     input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s %s got %0d want %0d", tag, what, got, want);
    end
  endtask

  task automatic checkOutput(input tv_t t, input string tag);
    cmp(tag, "rs1_sel",     rs1_sel_o,           t.e1);
    cmp(tag, "rs2_sel",     rs2_sel_o,           t.e2);
    cmp(tag, "stall_if",    {1'b0, stall_if_o},  {1'b0, t.flags[4]});
    cmp(tag, "stall_id",    {1'b0, stall_id_o},  {1'b0, t.flags[4]});
    cmp(tag, "bubble_ex",   {1'b0, bubble_ex_o}, {1'b0, t.flags[3]});
    cmp(tag, "flush_id",    {1'b0, flush_id_o},  {1'b0, t.flags[2]});
    cmp(tag, "stall_ex",    {1'b0, stall_ex_o},  {1'b0, t.flags[1]});
    cmp(tag, "div_start",   {1'b0, div_start_o}, {1'b0, t.flags[0]});
  endtask

  // Called just after a rising edge; checks at the falling edge
  task automatic step(input tv_t t, input string tag);
    applyStimulus(t);
    @(negedge clk);
    checkOutput(t, tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(idl());
    #12;
    checkOutput(idl(), "reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add x5 ; sub x6,x5,x1 -> rs1 from EX/LS
    tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 5, 1, 6, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 5'b00000));
    drain();
    // add x5 ; and x8 ; xor x9 ; or x7,x0,x5 -> rs2 from WB (retired)
    tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 1, 2, 8, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 3, 4, 9, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 0, 5, 7, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 5'b00000));
    drain();
    // add x5 ; and x8 ; or x7,x0,x5 -> rs2 from LS/WB
    tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 1, 2, 8, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 0, 5, 7, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 5'b00000));
    drain();
    // add x5 ; sub x5 ; or x7,x5,x0 -> youngest producer (EX/LS) wins
    tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 5, 0, 7, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 5'b00000));
    drain();
    // writes to x0 (ALU and load) never forward or stall
    tbl.push_back(mk(1, 1, 2, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 0, 0, 6, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    drain();
    // lw x5 ; add x6,x5,x5 -> one stall+bubble, then both from LS/WB
    tbl.push_back(mk(1, 1, 0, 5, 1, 1, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 5, 5, 6, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b11000));
    tbl.push_back(mk(1, 5, 5, 6, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 5'b00000));
    drain();
    // lw x5 ; add x6,x1,x5 -> load-use through rs2 only
    tbl.push_back(mk(1, 1, 0, 5, 1, 1, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 1, 5, 6, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b11000));
    tbl.push_back(mk(1, 1, 5, 6, 1, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 5'b00000));
    drain();
    // lw x5 ; add x6,x5,x5 with a taken jump -> flush+bubble, no stall
    tbl.push_back(mk(1, 1, 0, 5, 1, 1, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    tbl.push_back(mk(1, 5, 5, 6, 1, 0, 0, 1, 0, 2'd0, 2'd0, 5'b01100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'b00000));
    drain();

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("tbl%0d", i));
    end

    // div x10 enters EX, then div x11 waits in ID behind it
    step(mk(1, 1, 2, 10, 1, 0, 1, 0, 0, 2'd0, 2'd0, 5'b00000), "div_issue");
    step(mk(1, 3, 4, 11, 1, 0, 1, 0, 0, 2'd0, 2'd0, 5'b10011), "div_start");
    for (int i = 0; i < 32; i++) begin
      step(mk(1, 3, 4, 11, 1, 0, 1, 0, 0, 2'd0, 2'd0, 5'b10010), $sformatf("div_busy%0d", i));
    end
    step(mk(1, 3, 4, 11, 1, 0, 1, 0, 1, 2'd0, 2'd0, 5'b00000), "div_done");
    // back-to-back divide restarts the sequence
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'b10011), "div2_start");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'b10010), "div2_busy");
    // a jump during the divide stall is masked
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 5'b10010), "div2_jump");

    // reset mid-division clears outputs and returns to IDLE
    applyStimulus(idl());
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(idl(), "rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(idl(), "post_rst");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 5'b00000), "done_idle");
    step(idl(), "done_idle_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
